// File: rtl/srpt_pkg.sv
// Shared definitions for the SRPT grant path.
// Holds the header layout (width and field ranges), the arbiter FSM state type and a small
// helper that packs header fields into a flat header word.
package srpt_pkg;

    localparam int unsigned HEADER_SIZE = 58;

    // Header field ranges, MSB first.
    localparam int unsigned HDR_PEER_ID_HI  = 57;
    localparam int unsigned HDR_PEER_ID_LO  = 44;
    localparam int unsigned HDR_RPC_ID_HI   = 43;
    localparam int unsigned HDR_RPC_ID_LO   = 30;
    localparam int unsigned HDR_MSG_LEN_HI  = 29;
    localparam int unsigned HDR_MSG_LEN_LO  = 20;
    localparam int unsigned HDR_INCOMING_HI = 19;
    localparam int unsigned HDR_INCOMING_LO = 10;
    localparam int unsigned HDR_OFFSET_HI   = 9;
    localparam int unsigned HDR_OFFSET_LO   = 0;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2
    } arb_state_e;

    function automatic logic [HEADER_SIZE-1:0] make_header(
        input logic [13:0] peer_id,
        input logic [13:0] rpc_id,
        input logic [9:0]  msg_len,
        input logic [9:0]  incoming,
        input logic [9:0]  offset
    );
        logic [HEADER_SIZE-1:0] hdr;
        hdr = '0;
        hdr[HDR_PEER_ID_HI:HDR_PEER_ID_LO]   = peer_id;
        hdr[HDR_RPC_ID_HI:HDR_RPC_ID_LO]     = rpc_id;
        hdr[HDR_MSG_LEN_HI:HDR_MSG_LEN_LO]   = msg_len;
        hdr[HDR_INCOMING_HI:HDR_INCOMING_LO] = incoming;
        hdr[HDR_OFFSET_HI:HDR_OFFSET_LO]     = offset;
        return hdr;
    endfunction

endpackage

// File: rtl/srpt_hdr_fifo.sv
// First-word-fall-through circular header buffer.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   push_i/push_data_i write one entry (ignored when full unless a pop happens too)
//   pop_i              remove the head entry (ignored when empty)
//   empty_o, full_o    occupancy flags
//   count_o            number of stored entries
//   data_o             head entry; holds the last popped value while empty
module srpt_hdr_fifo #(
    parameter int unsigned HDR_W = 58,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [HDR_W-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic [HDR_W-1:0]           data_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [HDR_W-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [HDR_W-1:0] last_q, last_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntW'(DEPTH));
    assign count_o = count_q;

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Once drained, keep presenting the last entry that left the buffer.
    assign data_o = empty_o ? last_q : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        last_d   = last_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
            last_d   = mem_q[rd_ptr_q];
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            last_q   <= last_d;
        end
    end

    // Storage needs no reset: it is only observed through count_q.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/srpt_grant_hdr_arbiter.sv
// Round-robin merge of NUM_SRC FWFT header FIFOs into one FWFT header stream.
// Ports:
//   ap_clk, ap_rst_n    clock, asynchronous active-low reset
//   enable_i            1 = accept headers, 0 = stop accepting and drain
//   src_empty_i         per-source FIFO empty
//   src_read_en_o       per-source pop, one-hot or zero
//   src_data_i          per-source head header, source s at [s*HDR_W +: HDR_W]
//   hdr_out_empty_o     merged stream empty
//   hdr_out_read_en_i   merged stream pop
//   hdr_out_data_o      merged stream head header
//   idle_o              controller idle
//   accepted_cnt_o      headers accepted since reset (wraps)
module srpt_grant_hdr_arbiter
    import srpt_pkg::*;
#(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned HDR_W   = HEADER_SIZE,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst_n,
    input  logic                     enable_i,
    input  logic [NUM_SRC-1:0]       src_empty_i,
    output logic [NUM_SRC-1:0]       src_read_en_o,
    input  logic [NUM_SRC*HDR_W-1:0] src_data_i,
    output logic                     hdr_out_empty_o,
    input  logic                     hdr_out_read_en_i,
    output logic [HDR_W-1:0]         hdr_out_data_o,
    output logic                     idle_o,
    output logic [31:0]              accepted_cnt_o
);

    localparam int unsigned RrW  = $clog2(NUM_SRC);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    arb_state_e       state_q, state_d;
    logic [RrW-1:0]   rr_q, rr_d;
    logic [31:0]      cnt_q, cnt_d;

    logic             fifo_empty, fifo_full;
    logic [CntW-1:0]  fifo_count;
    logic             pop_ok, can_push;
    logic             grant_valid;
    logic [RrW-1:0]   grant_idx;
    logic [RrW-1:0]   scan_idx [NUM_SRC];
    logic [HDR_W-1:0] push_data;

    assign pop_ok   = hdr_out_read_en_i && !fifo_empty;
    // A full buffer may still take a header when the downstream frees a slot this cycle.
    assign can_push = !fifo_full || pop_ok;

    // Search order rr, rr+1, ... modulo NUM_SRC.
    always_comb begin
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            scan_idx[k] = RrW'((32'(rr_q) + k) % NUM_SRC);
        end
    end

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        if (state_q == StRun && can_push) begin
            for (int unsigned k = 0; k < NUM_SRC; k++) begin
                if (!grant_valid && !src_empty_i[scan_idx[k]]) begin
                    grant_valid = 1'b1;
                    grant_idx   = scan_idx[k];
                end
            end
        end
    end

    always_comb begin
        src_read_en_o = '0;
        if (grant_valid) begin
            src_read_en_o[grant_idx] = 1'b1;
        end
    end

    assign push_data = src_data_i[32'(grant_idx) * HDR_W +: HDR_W];

    always_comb begin
        rr_d  = rr_q;
        cnt_d = cnt_q;
        if (grant_valid) begin
            rr_d  = (32'(grant_idx) == NUM_SRC - 1) ? '0 : grant_idx + RrW'(1);
            cnt_d = cnt_q + 32'd1;
        end
    end

    // Controller: state register, next-state logic, output decode.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (enable_i) state_d = StRun;
            StRun:   if (!enable_i) state_d = StDrain;
            StDrain: begin
                if (enable_i) begin
                    state_d = StRun;
                end else if (fifo_count == '0) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        idle_o = (state_q == StIdle);
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rr_q  <= rr_d;
            cnt_q <= cnt_d;
        end
    end

    assign accepted_cnt_o = cnt_q;

    srpt_hdr_fifo #(
        .HDR_W (HDR_W),
        .DEPTH (DEPTH)
    ) u_out_fifo (
        .clk_i       (ap_clk),
        .rst_ni      (ap_rst_n),
        .push_i      (grant_valid),
        .push_data_i (push_data),
        .pop_i       (hdr_out_read_en_i),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full),
        .count_o     (fifo_count),
        .data_o      (hdr_out_data_o)
    );

    assign hdr_out_empty_o = fifo_empty;

endmodule

// File: tb/tb_srpt_grant_hdr_arbiter.sv
// Bench for srpt_grant_hdr_arbiter: queue-based model of sources, output stream and controller,
// compared against the DUT every cycle, plus directed scenarios with literal expectations.
module tb_srpt_grant_hdr_arbiter;
    import srpt_pkg::*;

    localparam int NUM_SRC = 4;
    localparam int HDR_W   = 58;
    localparam int DEPTH   = 4;
    localparam int SQ      = 64;
    localparam int MIdle   = 0;
    localparam int MRun    = 1;
    localparam int MDrain  = 2;

    logic                     ap_clk = 1'b0;
    logic                     ap_rst_n;
    logic                     enable_i;
    logic [NUM_SRC-1:0]       src_empty_i;
    logic [NUM_SRC-1:0]       src_read_en_o;
    logic [NUM_SRC*HDR_W-1:0] src_data_i;
    logic                     hdr_out_empty_o;
    logic                     hdr_out_read_en_i;
    logic [HDR_W-1:0]         hdr_out_data_o;
    logic                     idle_o;
    logic [31:0]              accepted_cnt_o;

    always #5 ap_clk = ~ap_clk;

    srpt_grant_hdr_arbiter #(
        .NUM_SRC (NUM_SRC),
        .HDR_W   (HDR_W),
        .DEPTH   (DEPTH)
    ) dut (
        .ap_clk            (ap_clk),
        .ap_rst_n          (ap_rst_n),
        .enable_i          (enable_i),
        .src_empty_i       (src_empty_i),
        .src_read_en_o     (src_read_en_o),
        .src_data_i        (src_data_i),
        .hdr_out_empty_o   (hdr_out_empty_o),
        .hdr_out_read_en_i (hdr_out_read_en_i),
        .hdr_out_data_o    (hdr_out_data_o),
        .idle_o            (idle_o),
        .accepted_cnt_o    (accepted_cnt_o)
    );

    int checks   = 0;
    int failures = 0;

    // Source FIFOs owned by the bench.
    logic [HDR_W-1:0] smem [NUM_SRC][SQ];
    int               shead [NUM_SRC];
    int               stail [NUM_SRC];

    // Behavioural model.
    logic [HDR_W-1:0] mq[$];
    int               m_state;
    int               m_rr;
    logic [31:0]      m_cnt;
    logic [HDR_W-1:0] m_last;
    logic             e_pop_ok;
    int               e_grant;

    // Values captured at the last sample point.
    logic [NUM_SRC-1:0] act_rd;
    logic               act_empty;
    logic               act_idle;
    logic [HDR_W-1:0]   act_data;
    logic [31:0]        act_cnt;

    int               grant_log[$];
    logic [HDR_W-1:0] out_log[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int socc(input int s);
        return stail[s] - shead[s];
    endfunction

    function automatic logic [HDR_W-1:0] hdr(input int s, input int i);
        return make_header(14'(s + 1), 14'(i), 10'(3 * s + i), 10'(0), 10'(i));
    endfunction

    task automatic push_src(input int s, input logic [HDR_W-1:0] h);
        smem[s][stail[s] % SQ] = h;
        stail[s]++;
    endtask

    task automatic drive_src();
        for (int s = 0; s < NUM_SRC; s++) begin
            src_empty_i[s] = (socc(s) == 0);
            src_data_i[s*HDR_W +: HDR_W] = smem[s][shead[s] % SQ];
        end
    endtask

    task automatic clear_src();
        for (int s = 0; s < NUM_SRC; s++) begin
            shead[s] = 0;
            stail[s] = 0;
            for (int j = 0; j < SQ; j++) smem[s][j] = '0;
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_state = MIdle;
        m_rr    = 0;
        m_cnt   = '0;
        m_last  = '0;
    endtask

    task automatic model_comb();
        int n;
        int s;
        n = mq.size();
        e_pop_ok = hdr_out_read_en_i && (n > 0);
        e_grant = -1;
        if (m_state == MRun && (n < DEPTH || (n == DEPTH && e_pop_ok))) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                s = (m_rr + k) % NUM_SRC;
                if (e_grant < 0 && socc(s) > 0) e_grant = s;
            end
        end
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic cycle();
        logic [NUM_SRC-1:0] e_rd;
        int n;
        @(negedge ap_clk);
        model_comb();
        e_rd = '0;
        if (e_grant >= 0) e_rd[e_grant] = 1'b1;
        act_rd    = src_read_en_o;
        act_empty = hdr_out_empty_o;
        act_idle  = idle_o;
        act_data  = hdr_out_data_o;
        act_cnt   = accepted_cnt_o;
        chk("src_read_en", act_rd, e_rd);
        chk("hdr_out_empty", act_empty, mq.size() == 0);
        chk("hdr_out_data", act_data, (mq.size() == 0) ? m_last : mq[0]);
        chk("idle", act_idle, m_state == MIdle);
        chk("accepted_cnt", act_cnt, m_cnt);
        for (int s = NUM_SRC - 1; s >= 0; s--) begin
            if (act_rd[s] && (act_rd & ((1 << s) - 1)) == 0) grant_log.push_back(s);
        end
        if (hdr_out_read_en_i && !act_empty) out_log.push_back(act_data);
        @(posedge ap_clk);
        if (ap_rst_n) begin
            n = mq.size();
            if (e_pop_ok) m_last = mq.pop_front();
            if (e_grant >= 0) begin
                mq.push_back(smem[e_grant][shead[e_grant] % SQ]);
                m_cnt++;
                m_rr = (e_grant + 1) % NUM_SRC;
            end
            case (m_state)
                MIdle:   if (enable_i) m_state = MRun;
                MRun:    if (!enable_i) m_state = MDrain;
                default: begin
                    if (enable_i) m_state = MRun;
                    else if (n == 0) m_state = MIdle;
                end
            endcase
            for (int s = 0; s < NUM_SRC; s++) begin
                if (act_rd[s] && socc(s) > 0) shead[s]++;
            end
        end
        #1;
        drive_src();
    endtask

    task automatic do_reset();
        ap_rst_n          = 1'b0;
        enable_i          = 1'b0;
        hdr_out_read_en_i = 1'b0;
        clear_src();
        model_reset();
        drive_src();
        grant_log.delete();
        out_log.delete();
        @(posedge ap_clk);
        @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_rd_en"}, src_read_en_o, 0);
        chk({tag, "_empty"}, hdr_out_empty_o, 1);
        chk({tag, "_data"}, hdr_out_data_o, 0);
        chk({tag, "_idle"}, idle_o, 1);
        chk({tag, "_cnt"}, accepted_cnt_o, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] r;
        ap_rst_n          = 1'b0;
        enable_i          = 1'b0;
        hdr_out_read_en_i = 1'b0;
        clear_src();
        model_reset();
        drive_src();
        #2;
        chk_reset_values("por");

        // Single header from source 0.
        do_reset();
        push_src(0, make_header(14'd5, 14'd5, 10'd5, 10'd0, 10'd0));
        drive_src();
        enable_i = 1'b1;
        cycle(); chk("t1_idle_wait", act_rd, 0);
        cycle(); chk("t1_grant", act_rd, 4'b0001);
        cycle();
        chk("t1_empty", act_empty, 0);
        chk("t1_data", act_data, 58'h500140500000);
        chk("t1_cnt", act_cnt, 1);

        // Round robin across four loaded sources with a free-flowing output.
        do_reset();
        for (int i = 0; i < 3; i++) for (int s = 0; s < NUM_SRC; s++) push_src(s, hdr(s, i));
        drive_src();
        enable_i = 1'b1;
        hdr_out_read_en_i = 1'b1;
        for (int c = 0; c < 40 && out_log.size() < 12; c++) cycle();
        chk("t2_ngrant", grant_log.size(), 12);
        chk("t2_nout", out_log.size(), 12);
        for (int k = 0; k < 12; k++) begin
            if (k < grant_log.size()) chk("t2_grant", grant_log[k], k % 4);
            if (k < out_log.size()) chk("t2_data", out_log[k], hdr(k % 4, k / 4));
        end
        cycle(); chk("t2_cnt", act_cnt, 12);

        // Backpressure: buffer fills, then one pop admits exactly one grant.
        do_reset();
        for (int s = 0; s < NUM_SRC; s++) for (int i = 0; i < 2; i++) push_src(s, hdr(s, i));
        drive_src();
        enable_i = 1'b1;
        repeat (12) cycle();
        chk("t3_ngrant", grant_log.size(), 4);
        chk("t3_stall", act_rd, 0);
        hdr_out_read_en_i = 1'b1;
        cycle(); chk("t3_pop_grant", act_rd, 4'b0001);
        hdr_out_read_en_i = 1'b0;
        repeat (6) cycle();
        chk("t3_total", grant_log.size(), 5);

        // Drain with three buffered, then resume from the saved pointer.
        do_reset();
        for (int s = 0; s < 3; s++) push_src(s, hdr(s, 7));
        drive_src();
        enable_i = 1'b1;
        repeat (6) cycle();
        chk("t4_fill", act_cnt, 3);
        enable_i = 1'b0;
        cycle();
        push_src(3, hdr(3, 7));
        drive_src();
        repeat (3) begin
            cycle();
            chk("t4_no_grant", act_rd, 0);
            chk("t4_not_idle", act_idle, 0);
        end
        hdr_out_read_en_i = 1'b1;
        repeat (3) begin
            cycle();
            chk("t4_draining", act_idle, 0);
        end
        hdr_out_read_en_i = 1'b0;
        cycle(); chk("t4_idle_lag", act_idle, 0);
        cycle(); chk("t4_idle", act_idle, 1);
        push_src(0, hdr(0, 8));
        drive_src();
        enable_i = 1'b1;
        cycle(); chk("t4_resume_wait", act_rd, 0);
        cycle(); chk("t4_resume_rr", act_rd, 4'b1000);
        cycle(); chk("t4_resume_next", act_rd, 4'b0001);

        // Pop on empty, then push and pop together while full.
        do_reset();
        hdr_out_read_en_i = 1'b1;
        repeat (3) begin
            cycle();
            chk("t5_empty_pop", act_empty, 1);
            chk("t5_empty_data", act_data, 0);
        end
        hdr_out_read_en_i = 1'b0;
        for (int i = 0; i < 6; i++) push_src(1, hdr(1, i));
        drive_src();
        enable_i = 1'b1;
        repeat (6) cycle();
        chk("t5_full_stall", act_rd, 0);
        hdr_out_read_en_i = 1'b1;
        cycle(); chk("t5_push_pop", act_rd, 4'b0010);
        hdr_out_read_en_i = 1'b0;
        cycle(); chk("t5_still_full", act_rd, 0);
        hdr_out_read_en_i = 1'b1;
        for (int c = 0; c < 20 && out_log.size() < 6; c++) cycle();
        chk("t5_nout", out_log.size(), 6);
        for (int k = 0; k < 6; k++) begin
            if (k < out_log.size()) chk("t5_order", out_log[k], hdr(1, k));
        end

        // Asynchronous reset with two buffered and a grant pending.
        do_reset();
        for (int i = 0; i < 2; i++) begin
            push_src(0, hdr(0, i));
            push_src(1, hdr(1, i));
        end
        drive_src();
        enable_i = 1'b1;
        repeat (3) cycle();
        @(negedge ap_clk);
        chk("t6_inflight", src_read_en_o, 4'b0001);
        #2;
        ap_rst_n = 1'b0;
        #1;
        chk_reset_values("t6_async");
        @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
        model_reset();
        enable_i = 1'b0;
        push_src(2, hdr(2, 9));
        drive_src();
        repeat (3) begin
            cycle();
            chk("t6_no_pop", act_rd, 0);
            chk("t6_empty", act_empty, 1);
        end
        enable_i = 1'b1;
        cycle();
        cycle(); chk("t6_rr_reset", act_rd, 4'b0001);

        // Randomised traffic against the model.
        do_reset();
        enable_i = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 19) == 0) enable_i = ~enable_i;
            hdr_out_read_en_i = ($urandom_range(0, 7) <= (c / 500));
            for (int s = 0; s < NUM_SRC; s++) begin
                if ($urandom_range(0, 3) == 0 && socc(s) < 8) begin
                    r = {$urandom, $urandom};
                    push_src(s, r[HDR_W-1:0]);
                end
            end
            drive_src();
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
